// File: rtl/load_store_unit.sv
// Load/store alignment unit: formats memory load data, replicates store data across
// byte lanes with matching byte enables, and flags misaligned accesses. One cycle of latency.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  LSUOP,
    input  logic [31:0] inData_load,
    input  logic [31:0] inData_store,
    input  logic [31:0] inAddr,
    output logic [31:0] outData_load,
    output logic [31:0] outData_store,
    output logic [15:0] outAddr,
    output logic [3:0]  outBE,
    output logic        outMisaligned
);

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } lsuOp_t;

    lsuOp_t      op;
    logic [15:0] halfSel;
    logic [7:0]  byteSel;
    logic [31:0] loadNext;
    logic [31:0] storeNext;
    logic [3:0]  beNext;
    logic        misalignedNext;

    assign op = lsuOp_t'(LSUOP);

    // Lane selection and formatting; misaligned accesses still select by the low address bits.
    always_comb begin
        halfSel        = inAddr[1] ? inData_load[31:16] : inData_load[15:0];
        byteSel        = 8'h00;
        loadNext       = 32'h0;
        storeNext      = 32'h0;
        beNext         = 4'b0000;
        misalignedNext = 1'b0;

        case (inAddr[1:0])
            2'd0:    byteSel = inData_load[7:0];
            2'd1:    byteSel = inData_load[15:8];
            2'd2:    byteSel = inData_load[23:16];
            default: byteSel = inData_load[31:24];
        endcase

        case (op)
            OP_LW: begin
                loadNext       = inData_load;
                misalignedNext = (inAddr[1:0] != 2'b00);
            end
            OP_LH: begin
                loadNext       = {{16{halfSel[15]}}, halfSel};
                misalignedNext = inAddr[0];
            end
            OP_LHU: begin
                loadNext       = {16'h0, halfSel};
                misalignedNext = inAddr[0];
            end
            OP_LB:  loadNext = {{24{byteSel[7]}}, byteSel};
            OP_LBU: loadNext = {24'h0, byteSel};
            OP_SW: begin
                storeNext      = inData_store;
                beNext         = 4'b1111;
                misalignedNext = (inAddr[1:0] != 2'b00);
            end
            OP_SH: begin
                storeNext      = {2{inData_store[15:0]}};
                beNext         = inAddr[1] ? 4'b1100 : 4'b0011;
                misalignedNext = inAddr[0];
            end
            default: begin
                storeNext = {4{inData_store[7:0]}};
                beNext    = 4'b0001 << inAddr[1:0];
            end
        endcase

        if (misalignedNext)
            beNext = 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outData_load  <= 32'h0;
            outData_store <= 32'h0;
            outAddr       <= 16'h0;
            outBE         <= 4'b0000;
            outMisaligned <= 1'b0;
        end else begin
            outData_load  <= loadNext;
            outData_store <= storeNext;
            outAddr       <= inAddr[15:0];
            outBE         <= beNext;
            outMisaligned <= misalignedNext;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases, a reset sequence and random ops
// checked against an arithmetic reference model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  LSUOP;
    logic [31:0] inData_load;
    logic [31:0] inData_store;
    logic [31:0] inAddr;
    logic [31:0] outData_load;
    logic [31:0] outData_store;
    logic [15:0] outAddr;
    logic [3:0]  outBE;
    logic        outMisaligned;

    int total = 0;
    int bad   = 0;

    logic [31:0] expLoad;
    logic [31:0] expStore;
    logic [15:0] expAddr;
    logic [3:0]  expBE;
    logic        expMis;

    load_store_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .LSUOP         (LSUOP),
        .inData_load   (inData_load),
        .inData_store  (inData_store),
        .inAddr        (inAddr),
        .outData_load  (outData_load),
        .outData_store (outData_store),
        .outAddr       (outAddr),
        .outBE         (outBE),
        .outMisaligned (outMisaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Reference model computed with shifts and arithmetic rather than lane muxes.
    function automatic void model(input int op, input logic [31:0] ld, input logic [31:0] st,
                                  input logic [31:0] addr);
        int unsigned a;
        logic [31:0] half;
        logic [31:0] bytev;
        a        = addr % 4;
        half     = (ld >> (16 * (a / 2))) & 32'hFFFF;
        bytev    = (ld >> (8 * a)) & 32'hFF;
        expLoad  = 32'h0;
        expStore = 32'h0;
        expBE    = 4'h0;
        expMis   = 1'b0;
        expAddr  = addr[15:0];
        case (op)
            0: begin expLoad = ld; expMis = (a != 0); end
            1: begin expLoad = (half >= 32'h8000) ? half + 32'hFFFF0000 : half; expMis = (a % 2 == 1); end
            2: begin expLoad = half; expMis = (a % 2 == 1); end
            3: expLoad = (bytev >= 32'h80) ? bytev + 32'hFFFFFF00 : bytev;
            4: expLoad = bytev;
            5: begin expStore = st; expBE = 4'hF; expMis = (a != 0); end
            6: begin expStore = (st & 32'hFFFF) * 32'h00010001; expBE = 4'h3 << (2 * (a / 2)); expMis = (a % 2 == 1); end
            default: begin expStore = (st & 32'hFF) * 32'h01010101; expBE = 4'h1 << a; end
        endcase
        if (expMis) expBE = 4'h0;
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, ".load"},  outData_load,          expLoad);
        checkOutput({tag, ".store"}, outData_store,         expStore);
        checkOutput({tag, ".addr"},  {16'h0, outAddr},      {16'h0, expAddr});
        checkOutput({tag, ".be"},    {28'h0, outBE},        {28'h0, expBE});
        checkOutput({tag, ".mis"},   {31'h0, outMisaligned}, {31'h0, expMis});
    endtask

    task automatic applyStimulus(input string tag, input int op, input logic [31:0] ld,
                                 input logic [31:0] st, input logic [31:0] addr);
        @(negedge clk);
        LSUOP        = 3'(op);
        inData_load  = ld;
        inData_store = st;
        inAddr       = addr;
        model(op, ld, st, addr);
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, ".load"},  outData_load,  32'h0);
        checkOutput({tag, ".store"}, outData_store, 32'h0);
        checkOutput({tag, ".addr"},  {16'h0, outAddr}, 32'h0);
        checkOutput({tag, ".be"},    {28'h0, outBE}, 32'h0);
        checkOutput({tag, ".mis"},   {31'h0, outMisaligned}, 32'h0);
    endtask

    initial begin
        rst_n        = 1'b0;
        LSUOP        = 3'd5;
        inData_load  = 32'hFFFFFFFF;
        inData_store = 32'hFFFFFFFF;
        inAddr       = 32'h0000FFFF;
        #12;
        checkZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int op = 0; op < 5; op++) applyStimulus("ld7f", op, 32'h7F7F7F7F, 32'hFFFFFFFF, 32'h0);
        for (int op = 0; op < 5; op++) applyStimulus("ld80", op, 32'h80808080, 32'hFFFFFFFF, 32'h0);
        for (int op = 5; op < 8; op++) applyStimulus("stAA", op, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h0);
        applyStimulus("sh2346", 6, 32'h0, 32'h12345678, 32'h00012346);
        applyStimulus("sb3",    7, 32'h0, 32'h12345678, 32'h00000003);
        applyStimulus("swMis",  5, 32'h0, 32'h12345678, 32'h00000002);
        applyStimulus("lhMis",  1, 32'h8001F100, 32'h0, 32'h00000001);
        applyStimulus("lb1",    3, 32'h0000F100, 32'h0, 32'h00000001);

        // Mid-cycle reset while outputs are nonzero, then release and recover.
        applyStimulus("preRst", 7, 32'h0, 32'hCAFEBABE, 32'h0000BEEF);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkZero("rstAsync");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkZero("rstHold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("postRst", 3, 32'h9A000000, 32'h0, 32'h00004443);

        for (int i = 0; i < 300; i++)
            applyStimulus("rand", int'($urandom_range(0, 7)), $urandom, $urandom, $urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
